// File: rtl/lsu.sv
// lsu: load/store unit between the instruction decoder and the data bus.
//
// Runs one request/grant/response bus transaction per memory instruction and
// stalls the single-cycle core until the access has completed. Loads return
// a sign- or zero-extended result for register writeback.
//
// Ports:
//   clk_i, rst_i          clock and synchronous active-high reset
//   mem_r_en_i            load requested by the decoder
//   mem_wr_en_i           store requested by the decoder (wins over load)
//   funct3_i              access size / sign
//   addr_i                effective byte address
//   wr_data_i             store data (rs2)
//   stall_o               freeze PC and register write
//   rd_data_o             extended load result (registered)
//   fault_o               misaligned address or illegal funct3 (IDLE only)
//   bus_req_o, bus_we_o, bus_addr_o, bus_be_o, bus_wdata_o
//                         data bus request; all zero while bus_req_o is low
//   bus_gnt_i             request accepted
//   bus_rvalid_i          response (load data valid or store ack)
//   bus_rdata_i           load data word
module lsu #(
    parameter int ADDR_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              mem_r_en_i,
    input  logic              mem_wr_en_i,
    input  logic [2:0]        funct3_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       wr_data_i,
    output logic              stall_o,
    output logic [31:0]       rd_data_o,
    output logic              fault_o,
    output logic              bus_req_o,
    output logic              bus_we_o,
    output logic [ADDR_W-1:0] bus_addr_o,
    output logic [3:0]        bus_be_o,
    output logic [31:0]       bus_wdata_o,
    input  logic              bus_gnt_i,
    input  logic              bus_rvalid_i,
    input  logic [31:0]       bus_rdata_i
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic               we_q, we_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [2:0]         funct3_q, funct3_d;
    logic [1:0]         off_q, off_d;
    logic [3:0]         be_q, be_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [31:0]        rd_data_q, rd_data_d;

    logic               acc_s;
    logic               illegal_s;
    logic               misalign_s;
    logic               fault_s;

    // Byte-enable mask for the access size, positioned at the byte offset.
    function automatic logic [3:0] size_mask(input logic [1:0] sz, input logic [1:0] off);
        logic [3:0] m;
        case (sz)
            2'd0:    m = 4'b0001 << off;
            2'd1:    m = 4'b0011 << off;
            2'd2:    m = 4'b1111;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

    // Store data replicated so every lane carries the value; be selects the lanes.
    function automatic logic [31:0] store_lanes(input logic [1:0] sz, input logic [31:0] d);
        logic [31:0] w;
        case (sz)
            2'd0:    w = {4{d[7:0]}};
            2'd1:    w = {2{d[15:0]}};
            2'd2:    w = d;
            default: w = 32'h0000_0000;
        endcase
        return w;
    endfunction

    // Pick the addressed byte/halfword out of the bus word and extend it.
    function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] off,
                                                 input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (off)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            2'd3:    b = w[31:24];
            default: b = 8'h00;
        endcase
        if (off[1]) begin
            h = w[31:16];
        end else begin
            h = w[15:0];
        end
        case (f3)
            3'd0:    r = {{24{b[7]}}, b};
            3'd1:    r = {{16{h[15]}}, h};
            3'd2:    r = w;
            3'd4:    r = {24'h00_0000, b};
            3'd5:    r = {16'h0000, h};
            default: r = 32'h0000_0000;
        endcase
        return r;
    endfunction

    // Decode of the instruction currently presented by the decoder.
    always_comb begin
        acc_s = mem_r_en_i | mem_wr_en_i;
        if (mem_wr_en_i) begin
            illegal_s = (funct3_i > 3'd2);
        end else begin
            illegal_s = (funct3_i == 3'd3) || (funct3_i == 3'd6) || (funct3_i == 3'd7);
        end
        misalign_s = ((funct3_i[1:0] == 2'd1) && addr_i[0]) ||
                     ((funct3_i[1:0] == 2'd2) && (addr_i[1:0] != 2'b00));
        fault_s = illegal_s | misalign_s;
    end

    // Next-state and latch logic for the transaction FSM.
    always_comb begin
        state_d   = state_q;
        we_d      = we_q;
        addr_d    = addr_q;
        funct3_d  = funct3_q;
        off_d     = off_q;
        be_d      = be_q;
        wdata_d   = wdata_q;
        rd_data_d = rd_data_q;
        case (state_q)
            S_IDLE: begin
                if (acc_s && !fault_s) begin
                    we_d     = mem_wr_en_i;
                    addr_d   = {addr_i[ADDR_W-1:2], 2'b00};
                    funct3_d = funct3_i;
                    off_d    = addr_i[1:0];
                    be_d     = size_mask(funct3_i[1:0], addr_i[1:0]);
                    if (mem_wr_en_i) begin
                        wdata_d = store_lanes(funct3_i[1:0], wr_data_i);
                    end else begin
                        wdata_d = 32'h0000_0000;
                    end
                    state_d = S_REQ;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_REQ: begin
                if (bus_gnt_i) begin
                    state_d = S_WAIT;
                end else begin
                    state_d = S_REQ;
                end
            end
            S_WAIT: begin
                if (bus_rvalid_i) begin
                    state_d = S_DONE;
                    if (!we_q) begin
                        rd_data_d = load_extract(funct3_q, off_q, bus_rdata_i);
                    end else begin
                        rd_data_d = rd_data_q;
                    end
                end else begin
                    state_d = S_WAIT;
                end
            end
            // The instruction is still presented here; returning to IDLE
            // first keeps it from being launched a second time.
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and latch registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            we_q      <= 1'b0;
            addr_q    <= {ADDR_W{1'b0}};
            funct3_q  <= 3'd0;
            off_q     <= 2'd0;
            be_q      <= 4'b0000;
            wdata_q   <= 32'h0000_0000;
            rd_data_q <= 32'h0000_0000;
        end else begin
            state_q   <= state_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            funct3_q  <= funct3_d;
            off_q     <= off_d;
            be_q      <= be_d;
            wdata_q   <= wdata_d;
            rd_data_q <= rd_data_d;
        end
    end

    // Stall, fault and bus outputs derived from state and latched fields.
    always_comb begin
        case (state_q)
            S_IDLE:  stall_o = acc_s & ~fault_s;
            S_REQ:   stall_o = 1'b1;
            S_WAIT:  stall_o = 1'b1;
            S_DONE:  stall_o = 1'b0;
            default: stall_o = 1'b0;
        endcase
        fault_o   = (state_q == S_IDLE) & acc_s & fault_s;
        bus_req_o = (state_q == S_REQ);
        if (bus_req_o) begin
            bus_we_o    = we_q;
            bus_addr_o  = addr_q;
            bus_be_o    = be_q;
            bus_wdata_o = wdata_q;
        end else begin
            bus_we_o    = 1'b0;
            bus_addr_o  = {ADDR_W{1'b0}};
            bus_be_o    = 4'b0000;
            bus_wdata_o = 32'h0000_0000;
        end
        rd_data_o = rd_data_q;
    end

endmodule

// File: tb/tb_lsu.sv
// tb_lsu: directed self-checking bench for lsu with hand-computed vectors.
module tb_lsu;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        mem_r_en_i;
    logic        mem_wr_en_i;
    logic [2:0]  funct3_i;
    logic [31:0] addr_i;
    logic [31:0] wr_data_i;
    logic        stall_o;
    logic [31:0] rd_data_o;
    logic        fault_o;
    logic        bus_req_o;
    logic        bus_we_o;
    logic [31:0] bus_addr_o;
    logic [3:0]  bus_be_o;
    logic [31:0] bus_wdata_o;
    logic        bus_gnt_i;
    logic        bus_rvalid_i;
    logic [31:0] bus_rdata_i;

    int n_checks = 0;
    int n_pass   = 0;

    lsu #(.ADDR_W(32)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .mem_r_en_i   (mem_r_en_i),
        .mem_wr_en_i  (mem_wr_en_i),
        .funct3_i     (funct3_i),
        .addr_i       (addr_i),
        .wr_data_i    (wr_data_i),
        .stall_o      (stall_o),
        .rd_data_o    (rd_data_o),
        .fault_o      (fault_o),
        .bus_req_o    (bus_req_o),
        .bus_we_o     (bus_we_o),
        .bus_addr_o   (bus_addr_o),
        .bus_be_o     (bus_be_o),
        .bus_wdata_o  (bus_wdata_o),
        .bus_gnt_i    (bus_gnt_i),
        .bus_rvalid_i (bus_rvalid_i),
        .bus_rdata_i  (bus_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        mem_r_en_i  = 1'b0;
        mem_wr_en_i = 1'b0;
        funct3_i    = 3'd0;
        addr_i      = 32'h0;
        wr_data_i   = 32'h0;
    endtask

    // One full access. gdly = REQ cycles before gnt, rdly = WAIT cycles before rvalid.
    task automatic access(input string tag, input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] d, input logic [31:0] rdata,
                          input int gdly, input int rdly,
                          input logic [31:0] e_addr, input logic [3:0] e_be,
                          input logic [31:0] e_wdata, input logic [31:0] e_rd, input int e_stall);
        int stalls;
        mem_r_en_i  = rd;
        mem_wr_en_i = wr;
        funct3_i    = f3;
        addr_i      = a;
        wr_data_i   = d;
        #1;
        chk({tag, "_fault"}, fault_o, 1'b0);
        stalls = stall_o ? 1 : 0;
        step();
        for (int k = 0; k <= gdly; k++) begin
            chk({tag, "_req"}, bus_req_o, 1'b1);
            chk({tag, "_addr"}, bus_addr_o, e_addr);
            chk({tag, "_be"}, bus_be_o, e_be);
            chk({tag, "_we"}, bus_we_o, wr);
            chk({tag, "_wdata"}, bus_wdata_o, e_wdata);
            if (stall_o) stalls++;
            bus_gnt_i = (k == gdly);
            // A stray rvalid while waiting for the grant must be ignored.
            bus_rvalid_i = (k != gdly);
            bus_rdata_i  = 32'hBADB_AD00;
            step();
            bus_gnt_i    = 1'b0;
            bus_rvalid_i = 1'b0;
        end
        for (int k = 0; k <= rdly; k++) begin
            chk({tag, "_wait_noreq"}, bus_req_o, 1'b0);
            if (stall_o) stalls++;
            bus_rvalid_i = (k == rdly);
            bus_rdata_i  = (k == rdly) ? rdata : 32'hBADB_AD01;
            step();
            bus_rvalid_i = 1'b0;
        end
        chk({tag, "_done_stall"}, stall_o, 1'b0);
        chk({tag, "_done_req"}, bus_req_o, 1'b0);
        chk({tag, "_rd"}, rd_data_o, e_rd);
        chk({tag, "_stalls"}, stalls, e_stall);
        // Instruction still presented in DONE: must not relaunch.
        step();
        chk({tag, "_no_relaunch"}, bus_req_o, 1'b0);
        idle_inputs();
        #1;
        step();
        chk({tag, "_idle_req"}, bus_req_o, 1'b0);
    endtask

    // Faulting access: no stall, no bus request, rd_data unchanged.
    task automatic fault_case(input string tag, input logic rd, input logic wr, input logic [2:0] f3,
                              input logic [31:0] a, input logic [31:0] e_rd);
        mem_r_en_i  = rd;
        mem_wr_en_i = wr;
        funct3_i    = f3;
        addr_i      = a;
        wr_data_i   = 32'h5555_AAAA;
        #1;
        chk({tag, "_fault"}, fault_o, 1'b1);
        chk({tag, "_stall"}, stall_o, 1'b0);
        step();
        chk({tag, "_req"}, bus_req_o, 1'b0);
        chk({tag, "_rd"}, rd_data_o, e_rd);
        idle_inputs();
        #1;
        chk({tag, "_fault_clr"}, fault_o, 1'b0);
        step();
    endtask

    initial begin
        idle_inputs();
        rst_i        = 1'b1;
        bus_gnt_i    = 1'b0;
        bus_rvalid_i = 1'b0;
        bus_rdata_i  = 32'h0;
        step();
        step();
        chk("rst_req", bus_req_o, 1'b0);
        chk("rst_we", bus_we_o, 1'b0);
        chk("rst_addr", bus_addr_o, 32'h0);
        chk("rst_be", bus_be_o, 4'b0000);
        chk("rst_wdata", bus_wdata_o, 32'h0);
        chk("rst_rd", rd_data_o, 32'h0);
        chk("rst_stall", stall_o, 1'b0);
        chk("rst_fault", fault_o, 1'b0);
        rst_i = 1'b0;
        step();

        //      tag    rd    wr    f3    addr          wdata          rdata          g  r  e_addr         be       e_wdata        e_rd           stalls
        access("lw",   1'b1, 1'b0, 3'd2, 32'h0000_0100, 32'h0,        32'hDEAD_BEEF, 0, 0, 32'h0000_0100, 4'b1111, 32'h0,        32'hDEAD_BEEF, 3);
        access("lb",   1'b1, 1'b0, 3'd0, 32'h0000_0103, 32'h0,        32'h80FF_1234, 0, 0, 32'h0000_0100, 4'b1000, 32'h0,        32'hFFFF_FF80, 3);
        access("lbu",  1'b1, 1'b0, 3'd4, 32'h0000_0103, 32'h0,        32'h80FF_1234, 0, 0, 32'h0000_0100, 4'b1000, 32'h0,        32'h0000_0080, 3);
        access("lh",   1'b1, 1'b0, 3'd1, 32'h0000_0102, 32'h0,        32'h80FF_1234, 0, 0, 32'h0000_0100, 4'b1100, 32'h0,        32'hFFFF_80FF, 3);
        access("lhu",  1'b1, 1'b0, 3'd5, 32'h0000_0102, 32'h0,        32'h80FF_1234, 0, 0, 32'h0000_0100, 4'b1100, 32'h0,        32'h0000_80FF, 3);
        access("lbo1", 1'b1, 1'b0, 3'd0, 32'h0000_0101, 32'h0,        32'h80FF_1234, 0, 0, 32'h0000_0100, 4'b0010, 32'h0,        32'h0000_0012, 3);
        access("sh",   1'b0, 1'b1, 3'd1, 32'h0000_0202, 32'hABCD_1234, 32'hFFFF_FFFF, 0, 0, 32'h0000_0200, 4'b1100, 32'h1234_1234, 32'h0000_0012, 3);
        access("sb",   1'b0, 1'b1, 3'd0, 32'h0000_0201, 32'hABCD_1234, 32'hFFFF_FFFF, 0, 0, 32'h0000_0200, 4'b0010, 32'h3434_3434, 32'h0000_0012, 3);
        access("sw2",  1'b1, 1'b1, 3'd2, 32'h0000_0300, 32'h1122_3344, 32'hFFFF_FFFF, 0, 0, 32'h0000_0300, 4'b1111, 32'h1122_3344, 32'h0000_0012, 3);

        fault_case("f_lw",  1'b1, 1'b0, 3'd2, 32'h0000_0102, 32'h0000_0012);
        fault_case("f_sh",  1'b0, 1'b1, 3'd1, 32'h0000_0201, 32'h0000_0012);
        fault_case("f_ld3", 1'b1, 1'b0, 3'd3, 32'h0000_0100, 32'h0000_0012);
        fault_case("f_st4", 1'b0, 1'b1, 3'd4, 32'h0000_0100, 32'h0000_0012);

        access("slow", 1'b1, 1'b0, 3'd2, 32'h0000_0404, 32'h0,        32'hCAFE_F00D, 2, 2, 32'h0000_0404, 4'b1111, 32'h0,        32'hCAFE_F00D, 7);

        // Reset while waiting for the response, then a late rvalid.
        mem_r_en_i = 1'b1;
        funct3_i   = 3'd2;
        addr_i     = 32'h0000_0500;
        step();
        chk("rstw_req", bus_req_o, 1'b1);
        bus_gnt_i = 1'b1;
        step();
        bus_gnt_i = 1'b0;
        chk("rstw_wait_stall", stall_o, 1'b1);
        rst_i = 1'b1;
        idle_inputs();
        step();
        chk("rstw_req0", bus_req_o, 1'b0);
        chk("rstw_rd0", rd_data_o, 32'h0);
        chk("rstw_stall0", stall_o, 1'b0);
        rst_i        = 1'b0;
        bus_rvalid_i = 1'b1;
        bus_rdata_i  = 32'h1234_5678;
        step();
        bus_rvalid_i = 1'b0;
        chk("late_rv_rd", rd_data_o, 32'h0);
        chk("late_rv_req", bus_req_o, 1'b0);
        chk("late_rv_stall", stall_o, 1'b0);
        step();
        chk("late_rv_rd2", rd_data_o, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
